// File: rtl/risc_mgmt_mem_port.sv
// ---------------------------------------------------------------------------
// risc_mgmt_mem_port
//
// Core-side responder for the risc_mgmt memory-stage extension interface.
// A load or store raised by the extension in IDLE is checked, latched, and
// then placed on the core data bus. The block holds the pipeline stalled
// until the bus completes. It then returns byte-lane-masked load data and
// writes the register file. Misaligned, illegal and timed-out requests
// produce a one-cycle fault pulse with a cause code.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   ext_mem_ren/wen      extension load / store request
//   ext_mem_addr         byte address of the request
//   ext_mem_store        store data
//   ext_mem_byte_en      byte-lane enables, bit i covers bits [8i+7:8i]
//   ext_reg_w, ext_rd    write load result to register file, destination reg
//   ext_exception        extension exception, suppresses new requests
//   ext_mem_load         masked load data (updated in DONE, held otherwise)
//   ext_mem_busy         request outstanding
//   stall_pipe           pipeline stall to the hazard unit
//   dbus_*               core data bus (ren/wen/addr/wdata/byte_en out,
//                        rdata/busy in; busy low = transfer completes)
//   rf_wen/rf_rd/rf_wdata register file write port
//   fault, fault_cause   one-cycle fault pulse; 1 misaligned, 2 illegal,
//                        3 bus timeout
// ---------------------------------------------------------------------------
module risc_mgmt_mem_port #(
    parameter int unsigned TIMEOUT = 255  // 1 .. 65535 busy cycles in ACCESS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ext_mem_ren,
    input  logic        ext_mem_wen,
    input  logic [31:0] ext_mem_addr,
    input  logic [31:0] ext_mem_store,
    input  logic [3:0]  ext_mem_byte_en,
    input  logic        ext_reg_w,
    input  logic [4:0]  ext_rd,
    input  logic        ext_exception,
    output logic [31:0] ext_mem_load,
    output logic        ext_mem_busy,
    output logic        stall_pipe,
    output logic        dbus_ren,
    output logic        dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_byte_en,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_busy,
    output logic        rf_wen,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    // Last busy cycle tolerated before the access is abandoned.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  be_q,      be_d;
    logic [4:0]  rd_q,      rd_d;
    logic        reg_w_q,   reg_w_d;
    logic        is_load_q, is_load_d;
    logic [1:0]  cause_q,   cause_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [31:0] load_q,    load_d;

    logic        req;
    logic [31:0] lane_mask;

    assign req       = (ext_mem_ren | ext_mem_wen) & ~ext_exception;
    assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    // NOTE: combinational blocks use blocking '=' and give every target a
    // default first, so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_d      = rd_q;
        reg_w_d   = reg_w_q;
        is_load_d = is_load_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        load_d    = load_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // Illegal takes priority over misaligned.
                    if ((ext_mem_ren && ext_mem_wen) || (ext_mem_byte_en == 4'b0000)) begin
                        state_d = ERROR;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (ext_mem_addr[1:0] != 2'b00) begin
                        state_d = ERROR;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        addr_d    = ext_mem_addr;
                        wdata_d   = ext_mem_store;
                        be_d      = ext_mem_byte_en;
                        rd_d      = ext_rd;
                        reg_w_d   = ext_reg_w;
                        is_load_d = ext_mem_ren;
                        cnt_d     = '0;
                        state_d   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!dbus_busy) begin
                    // Stores leave the last load value visible on ext_mem_load.
                    if (is_load_q) begin
                        load_d = dbus_rdata & lane_mask;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERROR;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state, including the latched request, is cleared by the
    // asynchronous reset so a reset mid-access leaves no stale transfer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= '0;
            reg_w_q   <= 1'b0;
            is_load_q <= 1'b0;
            cause_q   <= '0;
            cnt_q     <= '0;
            load_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_q      <= rd_d;
            reg_w_q   <= reg_w_d;
            is_load_q <= is_load_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
        end
    end

    always_comb begin
        ext_mem_busy = 1'b0;
        stall_pipe   = 1'b0;
        dbus_ren     = 1'b0;
        dbus_wen     = 1'b0;
        dbus_addr    = '0;
        dbus_wdata   = '0;
        dbus_byte_en = '0;
        rf_wen       = 1'b0;
        rf_rd        = '0;
        rf_wdata     = '0;
        fault        = 1'b0;
        fault_cause  = '0;

        case (state_q)
            IDLE: begin
                // Stall in the request cycle itself so the issuing
                // instruction is frozen; forced low while reset is held.
                stall_pipe   = req & nRST;
                ext_mem_busy = req & nRST;
            end
            ACCESS: begin
                stall_pipe   = 1'b1;
                ext_mem_busy = 1'b1;
                dbus_ren     = is_load_q;
                dbus_wen     = ~is_load_q;
                dbus_addr    = addr_q;
                dbus_wdata   = wdata_q;
                dbus_byte_en = be_q;
            end
            DONE: begin
                rf_wen = reg_w_q & is_load_q;
                if (reg_w_q && is_load_q) begin
                    rf_rd    = rd_q;
                    rf_wdata = load_q;
                end
            end
            ERROR: begin
                fault       = 1'b1;
                fault_cause = cause_q;
            end
            default: ;
        endcase
    end

    assign ext_mem_load = load_q;

endmodule

// File: tb/tb_risc_mgmt_mem_port.sv
// ---------------------------------------------------------------------------
// tb_risc_mgmt_mem_port
//
// Self-checking bench for risc_mgmt_mem_port (TIMEOUT = 4). Writebacks and
// faults are predicted into queues when a request is driven and popped by a
// negedge monitor when the DUT produces them. Inputs change #1 after the
// rising edge; cycle-level checks sample at that point.
// ---------------------------------------------------------------------------
module tb_risc_mgmt_mem_port;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        CLK;
    logic        nRST;
    logic        ext_mem_ren;
    logic        ext_mem_wen;
    logic [31:0] ext_mem_addr;
    logic [31:0] ext_mem_store;
    logic [3:0]  ext_mem_byte_en;
    logic        ext_reg_w;
    logic [4:0]  ext_rd;
    logic        ext_exception;
    logic [31:0] ext_mem_load;
    logic        ext_mem_busy;
    logic        stall_pipe;
    logic        dbus_ren;
    logic        dbus_wen;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_byte_en;
    logic [31:0] dbus_rdata;
    logic        dbus_busy;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;

    wb_t        exp_wb[$];
    logic [1:0] exp_fault[$];

    risc_mgmt_mem_port #(.TIMEOUT(4)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .ext_mem_ren     (ext_mem_ren),
        .ext_mem_wen     (ext_mem_wen),
        .ext_mem_addr    (ext_mem_addr),
        .ext_mem_store   (ext_mem_store),
        .ext_mem_byte_en (ext_mem_byte_en),
        .ext_reg_w       (ext_reg_w),
        .ext_rd          (ext_rd),
        .ext_exception   (ext_exception),
        .ext_mem_load    (ext_mem_load),
        .ext_mem_busy    (ext_mem_busy),
        .stall_pipe      (stall_pipe),
        .dbus_ren        (dbus_ren),
        .dbus_wen        (dbus_wen),
        .dbus_addr       (dbus_addr),
        .dbus_wdata      (dbus_wdata),
        .dbus_byte_en    (dbus_byte_en),
        .dbus_rdata      (dbus_rdata),
        .dbus_busy       (dbus_busy),
        .rf_wen          (rf_wen),
        .rf_rd           (rf_rd),
        .rf_wdata        (rf_wdata),
        .fault           (fault),
        .fault_cause     (fault_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ext_mem_ren     = 1'b0;
        ext_mem_wen     = 1'b0;
        ext_mem_addr    = '0;
        ext_mem_store   = '0;
        ext_mem_byte_en = '0;
        ext_reg_w       = 1'b0;
        ext_rd          = '0;
        ext_exception   = 1'b0;
        dbus_rdata      = '0;
        dbus_busy       = 1'b0;
    endtask

    task automatic release_req();
        clear_inputs();
        step();
    endtask

    // Scoreboard monitor: compare DUT-produced writebacks and faults.
    always @(negedge CLK) begin : monitor
        wb_t        e;
        logic [1:0] c;
        if (nRST) begin
            if (rf_wen) begin
                if (exp_wb.size() == 0) begin
                    check("sb_wb_unexpected", 32'(rf_rd), 32'hFFFF_FFFF);
                end else begin
                    e = exp_wb.pop_front();
                    check("sb_wb_rd", 32'(rf_rd), 32'(e.rd));
                    check("sb_wb_data", rf_wdata, e.data);
                end
            end
            if (fault) begin
                if (exp_fault.size() == 0) begin
                    check("sb_fault_unexpected", 32'(fault_cause), 32'hFFFF_FFFF);
                end else begin
                    c = exp_fault.pop_front();
                    check("sb_fault_cause", 32'(fault_cause), 32'(c));
                end
            end
        end
    end

    // Issue one request from IDLE and run its bus phase. The bus is busy
    // for the first 'waits' bus cycles. Returns with the DUT in the cycle
    // after ACCESS (DONE or ERROR) and the request still driven.
    task automatic xfer(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] store, input logic [3:0] be, input logic regw,
                        input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                        output int bus_cycles);
        wb_t e;
        ext_mem_ren     = ren;
        ext_mem_wen     = wen;
        ext_mem_addr    = addr;
        ext_mem_store   = store;
        ext_mem_byte_en = be;
        ext_reg_w       = regw;
        ext_rd          = rd;
        ext_exception   = 1'b0;
        dbus_rdata      = rdata;
        dbus_busy       = 1'b0;
        #1;
        check("idle_stall", 32'(stall_pipe), 32'd1);
        check("idle_busy", 32'(ext_mem_busy), 32'd1);
        if (ren && regw) begin
            e.rd   = rd;
            e.data = lane_mask(rdata, be);
            exp_wb.push_back(e);
        end
        bus_cycles = 0;
        step();
        for (int i = 0; i < 64; i++) begin
            if (!(dbus_ren || dbus_wen)) break;
            bus_cycles++;
            check("bus_dir", 32'({dbus_ren, dbus_wen}), 32'({ren, wen}));
            check("bus_addr", dbus_addr, addr);
            check("bus_be", 32'(dbus_byte_en), 32'(be));
            if (wen) check("bus_wdata", dbus_wdata, store);
            check("access_stall", 32'(stall_pipe), 32'd1);
            // Request inputs must be ignored once latched.
            ext_mem_addr    = ~addr;
            ext_mem_store   = ~store;
            ext_mem_byte_en = ~be;
            dbus_busy       = (bus_cycles <= waits);
            step();
        end
    endtask

    task automatic fault_req(input logic ren, input logic wen, input logic [31:0] addr,
                             input logic [3:0] be, input logic [1:0] cause);
        ext_mem_ren     = ren;
        ext_mem_wen     = wen;
        ext_mem_addr    = addr;
        ext_mem_byte_en = be;
        ext_reg_w       = 1'b1;
        ext_rd          = 5'd1;
        #1;
        check("flt_idle_stall", 32'(stall_pipe), 32'd1);
        exp_fault.push_back(cause);
        step();
        check("flt_pulse", 32'(fault), 32'd1);
        check("flt_cause", 32'(fault_cause), 32'(cause));
        check("flt_stall", 32'(stall_pipe), 32'd0);
        check("flt_no_bus", 32'({dbus_ren, dbus_wen}), 32'd0);
        check("flt_no_rf", 32'(rf_wen), 32'd0);
        release_req();
        check("flt_one_cycle", 32'(fault), 32'd0);
        check("flt_cause_clr", 32'(fault_cause), 32'd0);
    endtask

    initial begin : main
        int n;
        nRST = 1'b0;
        clear_inputs();
        #2;
        check("rst_stall", 32'(stall_pipe), 32'd0);
        check("rst_bus", 32'({dbus_ren, dbus_wen}), 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_load", ext_mem_load, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        step();

        // 1: word load, zero wait states.
        xfer(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'b1111, 1'b1, 5'd5, 32'hDEAD_BEEF, 0, n);
        check("t1_bus_cycles", 32'(n), 32'd1);
        check("t1_rf_wen", 32'(rf_wen), 32'd1);
        check("t1_rf_rd", 32'(rf_rd), 32'd5);
        check("t1_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("t1_done_stall", 32'(stall_pipe), 32'd0);
        check("t1_load", ext_mem_load, 32'hDEAD_BEEF);
        release_req();
        check("t1_load_hold", ext_mem_load, 32'hDEAD_BEEF);
        check("t1_rf_idle", rf_wdata, 32'd0);

        // 2: byte-lane load with three wait states.
        xfer(1'b1, 1'b0, 32'h0000_1010, 32'h0, 4'b0010, 1'b1, 5'd7, 32'h1122_3344, 3, n);
        check("t2_bus_cycles", 32'(n), 32'd4);
        check("t2_rf_wdata", rf_wdata, 32'h0000_3300);
        check("t2_rf_rd", 32'(rf_rd), 32'd7);
        release_req();

        // 3: store never writes the register file.
        xfer(1'b0, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'b1100, 1'b1, 5'd9, 32'h0, 0, n);
        check("t3_bus_cycles", 32'(n), 32'd1);
        check("t3_rf_wen", 32'(rf_wen), 32'd0);
        check("t3_load_kept", ext_mem_load, 32'h0000_3300);
        release_req();

        // 4: faults, including illegal-over-misaligned priority.
        fault_req(1'b1, 1'b0, 32'h0000_1002, 4'b1111, 2'd1);
        fault_req(1'b1, 1'b1, 32'h0000_1000, 4'b1111, 2'd2);
        fault_req(1'b1, 1'b0, 32'h0000_1000, 4'b0000, 2'd2);
        fault_req(1'b1, 1'b1, 32'h0000_1002, 4'b1111, 2'd2);

        // 5: bus stuck busy, TIMEOUT = 4.
        exp_fault.push_back(2'd3);
        xfer(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'b1111, 1'b0, 5'd3, 32'h55, 1000, n);
        check("t5_bus_cycles", 32'(n), 32'd4);
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_cause", 32'(fault_cause), 32'd3);
        check("t5_ren_drop", 32'(dbus_ren), 32'd0);
        release_req();
        check("t5_idle_ren", 32'(dbus_ren), 32'd0);
        check("t5_idle_fault", 32'(fault), 32'd0);

        // 6a: asynchronous reset mid-ACCESS.
        ext_mem_ren     = 1'b1;
        ext_mem_addr    = 32'h0000_4000;
        ext_mem_byte_en = 4'b1111;
        ext_reg_w       = 1'b1;
        ext_rd          = 5'd4;
        dbus_busy       = 1'b1;
        step();
        check("t6_access_ren", 32'(dbus_ren), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("t6_rst_ren", 32'(dbus_ren), 32'd0);
        check("t6_rst_stall", 32'(stall_pipe), 32'd0);
        check("t6_rst_busy", 32'(ext_mem_busy), 32'd0);
        check("t6_rst_addr", dbus_addr, 32'd0);
        check("t6_rst_load", ext_mem_load, 32'd0);
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;
        step();
        check("t6_idle_ren", 32'(dbus_ren), 32'd0);
        check("t6_idle_stall", 32'(stall_pipe), 32'd0);

        // 6b: extension exception suppresses a request.
        ext_mem_ren     = 1'b1;
        ext_mem_addr    = 32'h0000_1000;
        ext_mem_byte_en = 4'b1111;
        ext_reg_w       = 1'b1;
        ext_exception   = 1'b1;
        #1;
        check("t6_exc_stall", 32'(stall_pipe), 32'd0);
        check("t6_exc_busy", 32'(ext_mem_busy), 32'd0);
        step();
        check("t6_exc_no_bus1", 32'(dbus_ren), 32'd0);
        step();
        check("t6_exc_no_bus2", 32'(dbus_ren), 32'd0);
        release_req();

        // Normal operation after reset: split-lane load, one wait state.
        xfer(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'b1001, 1'b1, 5'd31, 32'hA1B2_C3D4, 1, n);
        check("t7_bus_cycles", 32'(n), 32'd2);
        check("t7_rf_wdata", rf_wdata, 32'hA100_00D4);
        release_req();
        step();

        check("sb_wb_drained", 32'(exp_wb.size()), 32'd0);
        check("sb_fault_drained", 32'(exp_fault.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_mgmt_mem_port.md
Name: risc_mgmt_mem_port

Overview:
- Core-side responder for the risc_mgmt memory-stage extension interface.
- Services load and store requests raised by an RV32 extension's memory stage, such as mem_ren/mem_wen.
- Sequences each request onto the core data bus with a ready/busy handshake.
- Stalls the pipeline while a request is outstanding, masks load data by byte lane, performs register writeback, and reports alignment, illegal-request and bus-timeout faults.

Parameters:
- TIMEOUT, 255: maximum number of ACCESS-state cycles with dbus_busy high before a bus fault is raised. Legal range 1 to 65535.

Ports:
- CLK  in  1  core clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ext_mem_ren  in  1  extension load request
- ext_mem_wen  in  1  extension store request
- ext_mem_addr  in  32  byte address of the request
- ext_mem_store  in  32  store data
- ext_mem_byte_en  in  4  byte-lane enables; bit i covers bits [8i+7:8i]
- ext_reg_w  in  1  write load result to register file
- ext_rd  in  5  destination register
- ext_exception  in  1  extension's own exception; suppresses acceptance of a new request
- ext_mem_load  out  32  masked load data returned to the extension
- ext_mem_busy  out  1  request outstanding; extension holds its request stable
- stall_pipe  out  1  pipeline stall request to the hazard unit
- dbus_ren  out  1  data bus read
- dbus_wen  out  1  data bus write
- dbus_addr  out  32  data bus address
- dbus_wdata  out  32  data bus write data
- dbus_byte_en  out  4  data bus byte enables
- dbus_rdata  in  32  data bus read data
- dbus_busy  in  1  data bus busy; low means the transfer completes this cycle
- rf_wen  out  1  register file write strobe
- rf_rd  out  5  register file write address
- rf_wdata  out  32  register file write data
- fault  out  1  one-cycle fault pulse
- fault_cause  out  2  fault code: 0 none, 1 misaligned, 2 illegal, 3 bus timeout

Behaviour:
- Reset (asynchronous, nRST low):
  - Every output is 0.
  - State returns to IDLE.
  - Latched request registers, load register and timeout counter are cleared.
  - Asserting reset mid-ACCESS abandons the transfer; dbus_ren and dbus_wen drop immediately.
- State machine: IDLE, ACCESS, DONE, ERROR.
- Request detection: req = (ext_mem_ren | ext_mem_wen) & ~ext_exception, sampled in IDLE only.
- IDLE, when req is set, checks are applied in priority order:
  - ren & wen both set, or byte_en = 0: go to ERROR, cause 2.
  - Otherwise ext_mem_addr[1:0] != 0: go to ERROR, cause 1.
  - Otherwise: latch addr, store data, byte_en, rd, reg_w and direction; clear the counter; go to ACCESS.
- IDLE outputs: stall_pipe and ext_mem_busy = req, combinationally. This freezes the issuing instruction in the same cycle.
- ACCESS:
  - Drives dbus_* from the latched registers. Exactly one of dbus_ren/dbus_wen is high.
  - stall_pipe = ext_mem_busy = 1.
  - dbus_busy = 0: capture dbus_rdata with non-enabled lanes zeroed, then go to DONE.
  - Otherwise the counter increments. When counter = TIMEOUT-1 and dbus_busy is still 1, go to ERROR with cause 3; the bus request drops on the next cycle.
- DONE (one cycle):
  - stall_pipe = ext_mem_busy = 0.
  - ext_mem_load = masked load data.
  - rf_wen = latched reg_w & load, with rf_rd/rf_wdata driven from the latches.
  - Stores never write the register file.
  - Next state is IDLE. A new request is not accepted in DONE.
- ERROR (one cycle): fault = 1, fault_cause = the latched code, stall_pipe = 0, no bus activity, no rf_wen. Next state is IDLE.
- ext_mem_load holds its last value outside DONE. rf_wdata and rf_rd are 0 whenever rf_wen = 0.
- Latency:
  - Zero-wait-state bus: request in IDLE at cycle 0, bus access at cycle 1, writeback at cycle 2.
  - Each bus wait state adds one cycle.
- ext_mem_* inputs are ignored outside IDLE. Latched values drive the bus even if the inputs change.

Test Plan:
1. Word load, zero wait: addr 0x1000, byte_en 1111, reg_w 1, rd 5, dbus_rdata 0xDEADBEEF, dbus_busy 0 -> dbus_ren high for 1 cycle at 0x1000. Cycle 2: rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF. stall_pipe high for cycles 0-1.
2. Byte-lane load with 3 wait states: byte_en 0010, dbus_rdata 0x11223344 -> dbus_ren held 4 cycles. rf_wdata=0x00003300 one cycle after dbus_busy falls.
3. Store: wen, addr 0x2004, data 0xCAFEF00D, byte_en 1100 -> dbus_wen, dbus_wdata=0xCAFEF00D, dbus_byte_en=1100. rf_wen never asserted.
4. Faults:
   - addr 0x1002 -> fault=1, cause 1, no dbus activity.
   - ren and wen both high -> cause 2.
   - byte_en 0000 -> cause 2.
5. Timeout: TIMEOUT=4, dbus_busy stuck high -> 4 ACCESS cycles, then fault with cause 3. Next cycle returns to IDLE with dbus_ren=0.
6. Reset and suppression:
   - nRST pulled low mid-ACCESS -> all outputs 0 asynchronously; after release, the state is IDLE.
   - ext_exception=1 with ren=1 -> no stall, no bus access.
